// File: rtl/pll_cfg_seq_if.sv
// Avalon-MM management port between pll_cfg_seq and the altera_pll_reconfig core.
interface pll_cfg_seq_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_write,
    output mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_write,
    input  mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/pll_cfg_seq.sv
// PLL run-time reconfiguration sequencer: latches an M/K/C0 counter set, writes
// it through the reconfig management port, starts reconfiguration and waits
// for the PLL to re-lock (done) or time out (lock_err).
module pll_cfg_seq #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_m_hi,
  input  logic [7:0]  cfg_m_lo,
  input  logic        cfg_m_odd,
  input  logic [31:0] cfg_k,
  input  logic [7:0]  cfg_c0_hi,
  input  logic [7:0]  cfg_c0_lo,
  input  logic        cfg_c0_odd,
  pll_cfg_seq_if.master mgmt,
  input  logic        pll_locked,
  output logic        busy,
  output logic        done,
  output logic        lock_err
);

  localparam int unsigned LCW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_MODE,
    S_WR_N,
    S_WR_M,
    S_WR_K,
    S_WR_C0,
    S_WR_START,
    S_SETTLE,
    S_WAIT_LOCK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d, wr_next;
  logic             gap_q, gap_d;
  logic [SCW-1:0]   settle_q, settle_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
  logic             lock_err_q, lock_err_d;
  logic             accept;
  logic             wr_active, wr_strobe;
  logic [5:0]       wr_addr;
  logic [31:0]      wr_data;
  logic             sync1_q, sync2_q;

  logic [7:0]       m_hi_q, m_lo_q, c0_hi_q, c0_lo_q;
  logic             m_odd_q, c0_odd_q;
  logic [31:0]      k_q;

  // Double-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Capture the requested counter set at acceptance; held for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi_q   <= '0;
      m_lo_q   <= '0;
      m_odd_q  <= 1'b0;
      k_q      <= '0;
      c0_hi_q  <= '0;
      c0_lo_q  <= '0;
      c0_odd_q <= 1'b0;
    end else if (accept) begin
      m_hi_q   <= cfg_m_hi;
      m_lo_q   <= cfg_m_lo;
      m_odd_q  <= cfg_m_odd;
      k_q      <= cfg_k;
      c0_hi_q  <= cfg_c0_hi;
      c0_lo_q  <= cfg_c0_lo;
      c0_odd_q <= cfg_c0_odd;
    end
  end

  // State, counters and sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gap_q      <= 1'b0;
      settle_q   <= '0;
      lock_cnt_q <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      settle_q   <= settle_d;
      lock_cnt_q <= lock_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Next-state logic and per-state register write selection.
  // gap_q forces one idle cycle after each completed write, so every write
  // state spends its first cycle after a transfer with mgmt_write low.
  always_comb begin
    state_d    = state_q;
    gap_d      = 1'b0;
    settle_d   = '0;
    lock_cnt_d = '0;
    lock_err_d = lock_err_q;
    accept     = 1'b0;
    wr_active  = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_next    = state_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          accept     = 1'b1;
          lock_err_d = 1'b0;
          state_d    = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        wr_active = 1'b1;
        wr_addr   = 6'h00;
        wr_data   = 32'h0000_0000;
        wr_next   = S_WR_N;
      end
      S_WR_N: begin
        wr_active = 1'b1;
        wr_addr   = 6'h03;
        wr_data   = 32'h0001_0000;
        wr_next   = S_WR_M;
      end
      S_WR_M: begin
        wr_active = 1'b1;
        wr_addr   = 6'h04;
        wr_data   = {14'b0, m_odd_q, 1'b0, m_hi_q, m_lo_q};
        wr_next   = S_WR_K;
      end
      S_WR_K: begin
        wr_active = 1'b1;
        wr_addr   = 6'h07;
        wr_data   = k_q;
        wr_next   = S_WR_C0;
      end
      S_WR_C0: begin
        wr_active = 1'b1;
        wr_addr   = 6'h05;
        wr_data   = {9'b0, 5'd0, c0_odd_q, 1'b0, c0_hi_q, c0_lo_q};
        wr_next   = S_WR_START;
      end
      S_WR_START: begin
        wr_active = 1'b1;
        wr_addr   = 6'h02;
        wr_data   = 32'h0000_0001;
        wr_next   = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SCW'(SETTLE_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested before the timeout so a coincident lock still succeeds.
        if (sync2_q) begin
          state_d = S_DONE;
        end else if (lock_cnt_q == LCW'(LOCK_TIMEOUT)) begin
          state_d    = S_ERR;
          lock_err_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wr_strobe = wr_active & ~gap_q;
    if (wr_strobe && !mgmt.mgmt_waitrequest) begin
      state_d = wr_next;
      gap_d   = 1'b1;
    end
  end

  assign mgmt.mgmt_write     = wr_strobe;
  assign mgmt.mgmt_address   = wr_strobe ? wr_addr : '0;
  assign mgmt.mgmt_writedata = wr_strobe ? wr_data : '0;

  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign done     = (state_q == S_DONE);
  assign lock_err = lock_err_q;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq: write ordering/data, waitrequest stalls,
// busy-time request masking, lock timeout, lock/timeout coincidence, async reset.
module tb_pll_cfg_seq;

  localparam int unsigned SETTLE = 16;
  localparam int unsigned LT     = 40;

  logic        clk;
  logic        rst_n;
  logic        cfg_req;
  logic [7:0]  cfg_m_hi, cfg_m_lo, cfg_c0_hi, cfg_c0_lo;
  logic        cfg_m_odd, cfg_c0_odd;
  logic [31:0] cfg_k;
  logic        pll_locked;
  logic        busy, done, lock_err;

  pll_cfg_seq_if mgmt ();

  pll_cfg_seq #(
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (LT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_req    (cfg_req),
    .cfg_m_hi   (cfg_m_hi),
    .cfg_m_lo   (cfg_m_lo),
    .cfg_m_odd  (cfg_m_odd),
    .cfg_k      (cfg_k),
    .cfg_c0_hi  (cfg_c0_hi),
    .cfg_c0_lo  (cfg_c0_lo),
    .cfg_c0_odd (cfg_c0_odd),
    .mgmt       (mgmt),
    .pll_locked (pll_locked),
    .busy       (busy),
    .done       (done),
    .lock_err   (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Bus monitor: records every completed write and protocol violations.
  logic [5:0]  cap_a [64];
  logic [31:0] cap_d [64];
  int          ncap     = 0;
  int          done_cnt = 0;
  int          gap_err  = 0;
  int          idle_err = 0;
  logic        prev_cmp = 1'b0;

  always @(posedge clk) begin
    if (mgmt.mgmt_write && !mgmt.mgmt_waitrequest && ncap < 64) begin
      cap_a[ncap] <= mgmt.mgmt_address;
      cap_d[ncap] <= mgmt.mgmt_writedata;
      ncap        <= ncap + 1;
    end
    if (mgmt.mgmt_write && prev_cmp) gap_err <= gap_err + 1;
    if (!mgmt.mgmt_write && (mgmt.mgmt_address != 6'h00 || mgmt.mgmt_writedata != 32'h0))
      idle_err <= idle_err + 1;
    prev_cmp <= mgmt.mgmt_write && !mgmt.mgmt_waitrequest;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int count_addr(input int from, input logic [5:0] a);
    int c = 0;
    for (int i = from; i < ncap; i++) if (cap_a[i] == a) c++;
    return c;
  endfunction

  // Applies a one-cycle request pulse; returns at the negedge after acceptance.
  task automatic req(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                     input logic [31:0] k, input logic [7:0] ch, input logic [7:0] cl,
                     input logic co);
    @(negedge clk);
    cfg_m_hi = mh; cfg_m_lo = ml; cfg_m_odd = mo; cfg_k = k;
    cfg_c0_hi = ch; cfg_c0_lo = cl; cfg_c0_odd = co;
    pll_locked = 1'b0;
    mgmt.mgmt_waitrequest = 1'b0;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
  endtask

  // Acts as the reconfig core until the Start write is about to complete,
  // stalling the write at stall_addr for stall_len cycles. Returns just after
  // the edge on which Start completes.
  task automatic run_writes(input logic [5:0] stall_addr, input int stall_len,
                            output int stalls, output int unstable);
    bit          seen = 0;
    logic [5:0]  a0 = '0;
    logic [31:0] d0 = '0;
    stalls = 0;
    unstable = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (mgmt.mgmt_write && mgmt.mgmt_address == stall_addr && stalls < stall_len) begin
        if (stalls == 0) begin
          a0 = mgmt.mgmt_address;
          d0 = mgmt.mgmt_writedata;
        end else if (mgmt.mgmt_address != a0 || mgmt.mgmt_writedata != d0) begin
          unstable++;
        end
        mgmt.mgmt_waitrequest = 1'b1;
        stalls++;
      end else begin
        if (stalls > 0 && stalls < stall_len) unstable++;
        mgmt.mgmt_waitrequest = 1'b0;
        if (mgmt.mgmt_write && mgmt.mgmt_address == 6'h02) seen = 1;
      end
    end
    check("start_write_seen", 32'(seen), 32'd1);
    @(posedge clk);
  endtask

  task automatic wait_done(output logic busy_at_done);
    bit found = 0;
    busy_at_done = 1'bx;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        busy_at_done = busy;
      end
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_seq(input string tag, input int base, input logic [31:0] m_data,
                           input logic [31:0] k_data, input logic [31:0] c0_data);
    logic [5:0]  ea [6];
    logic [31:0] ed [6];
    ea = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h05, 6'h02};
    ed = '{32'h0, 32'h0001_0000, m_data, k_data, c0_data, 32'h1};
    check({tag, "_wr_count"}, 32'(ncap - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 32'(cap_a[base + i]), 32'(ea[i]));
      check($sformatf("%s_wr%0d_data", tag, i), cap_d[base + i], ed[i]);
    end
  endtask

  initial begin
    int   mark, dc0, stalls, unstable, seen5;
    logic bz;

    rst_n = 1'b0; cfg_req = 1'b0; pll_locked = 1'b0;
    cfg_m_hi = '0; cfg_m_lo = '0; cfg_m_odd = 1'b0; cfg_k = '0;
    cfg_c0_hi = '0; cfg_c0_lo = '0; cfg_c0_odd = 1'b0;
    mgmt.mgmt_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lock_err", 32'(lock_err), 32'd0);
    check("rst_write", 32'(mgmt.mgmt_write), 32'd0);
    check("rst_addr", 32'(mgmt.mgmt_address), 32'd0);
    check("rst_data", mgmt.mgmt_writedata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sequence, no stalls, lock 5 cycles after settle.
    mark = ncap; dc0 = done_cnt;
    req(8'h07, 8'h06, 1'b1, 32'h5C28_F5C3, 8'h02, 8'h02, 1'b0);
    check("t1_busy_after_accept", 32'(busy), 32'd1);
    run_writes(6'h3f, 0, stalls, unstable);
    repeat (SETTLE + 5) @(posedge clk);
    @(negedge clk) pll_locked = 1'b1;
    wait_done(bz);
    check("t1_busy_at_done", 32'(bz), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_done_pulses", 32'(done_cnt - dc0), 32'd1);
    check_seq("t1", mark, 32'h0002_0706, 32'h5C28_F5C3, 32'h0000_0202);

    // K write stalled 20 cycles; request and data changes while busy are ignored.
    mark = ncap; dc0 = done_cnt;
    req(8'h12, 8'h11, 1'b0, 32'h1234_5678, 8'h05, 8'h04, 1'b1);
    @(negedge clk);
    cfg_m_hi = 8'hAA; cfg_m_lo = 8'hBB; cfg_m_odd = 1'b1; cfg_k = 32'hDEAD_BEEF;
    cfg_c0_hi = 8'hCC; cfg_c0_lo = 8'hDD; cfg_c0_odd = 1'b0;
    cfg_req = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    run_writes(6'h07, 20, stalls, unstable);
    check("t2_stall_cycles", 32'(stalls), 32'd20);
    check("t2_stall_stable", 32'(unstable), 32'd0);
    repeat (SETTLE + 2) @(posedge clk);
    @(negedge clk) pll_locked = 1'b1;
    wait_done(bz);
    repeat (3) @(negedge clk);
    check("t2_no_retrigger", 32'(busy), 32'd0);
    check("t2_done_pulses", 32'(done_cnt - dc0), 32'd1);
    check("t2_k_writes", 32'(count_addr(mark, 6'h07)), 32'd1);
    check_seq("t2", mark, 32'h0000_1211, 32'h1234_5678, 32'h0002_0504);

    // Lock never arrives: timeout exactly SETTLE+LT+1 cycles after Start completes.
    dc0 = done_cnt;
    req(8'h03, 8'h03, 1'b0, 32'h0, 8'h01, 8'h01, 1'b1);
    run_writes(6'h3f, 0, stalls, unstable);
    repeat (SETTLE + LT) @(posedge clk);
    #1;
    check("t3_no_err_early", 32'(lock_err), 32'd0);
    check("t3_busy_before_to", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("t3_lock_err", 32'(lock_err), 32'd1);
    check("t3_busy_after_to", 32'(busy), 32'd0);
    check("t3_no_done", 32'(done), 32'd0);
    repeat (5) @(negedge clk);
    check("t3_lock_err_sticky", 32'(lock_err), 32'd1);
    check("t3_done_pulses", 32'(done_cnt - dc0), 32'd0);

    // New request clears lock_err; reset asserted while C0 write is stalled.
    req(8'h03, 8'h03, 1'b0, 32'h0, 8'h01, 8'h01, 1'b1);
    check("t5_lock_err_cleared", 32'(lock_err), 32'd0);
    mark = ncap; seen5 = 0;
    for (int i = 0; i < 100 && seen5 < 3; i++) begin
      @(negedge clk);
      if (mgmt.mgmt_write && mgmt.mgmt_address == 6'h05) begin
        mgmt.mgmt_waitrequest = 1'b1;
        seen5++;
      end else begin
        mgmt.mgmt_waitrequest = 1'b0;
      end
    end
    check("t5_c0_stall_reached", 32'(seen5), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_write", 32'(mgmt.mgmt_write), 32'd0);
    check("t5_rst_addr", 32'(mgmt.mgmt_address), 32'd0);
    check("t5_rst_data", mgmt.mgmt_writedata, 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t5_c0_not_written", 32'(count_addr(mark, 6'h05)), 32'd0);
    check("t5_partial_writes", 32'(ncap - mark), 32'd4);
    rst_n = 1'b1;
    mgmt.mgmt_waitrequest = 1'b0;
    @(negedge clk);
    check("t5_idle_after_rst", 32'(busy), 32'd0);

    // Restart from WR_MODE; lock arrives on the very cycle the timeout expires.
    mark = ncap;
    req(8'h07, 8'h06, 1'b1, 32'h5C28_F5C3, 8'h02, 8'h02, 1'b0);
    run_writes(6'h3f, 0, stalls, unstable);
    repeat (SETTLE + LT - 2) @(posedge clk);
    @(negedge clk) pll_locked = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_still_waiting", 32'(done), 32'd0);
    check("t6_busy_waiting", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("t6_done", 32'(done), 32'd1);
    check("t6_lock_err", 32'(lock_err), 32'd0);
    repeat (3) @(negedge clk);
    check_seq("t6", mark, 32'h0002_0706, 32'h5C28_F5C3, 32'h0000_0202);

    check("write_gap_violations", 32'(gap_err), 32'd0);
    check("idle_bus_nonzero", 32'(idle_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
